ascon_serial_io: RTL

Parametrised serial front-end for the Ascon encryption core. It deserialises masked key, nonce, associated data and plaintext from W-bit-per-beat, SHARES-way shared lanes using a valid/ready handshake, and launches the core with a one-cycle start pulse. It then captures ciphertext and tag and streams them out W bits per beat under back-pressure. It sits between the chip-level serial pins and the Ascon core. It replaces the fixed 1-bit, free-running shift-in/shift-out scheme with a flow-controlled, width- and share-configurable one.

---
 rtl/ascon_io_pkg.sv | 28 ++
 rtl/ascon_share_shreg.sv | 53 +++++
 rtl/ascon_serial_io.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ascon_io_pkg.sv
// Shared types and elaboration helpers for the Ascon serial front-end.
package ascon_io_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } ioState_e;

  localparam int KEY_BITS   = 128;
  localparam int NONCE_BITS = 128;
  localparam int TAG_BITS   = 128;

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int beatCount(input int bits, input int w);
    return bits / w;
  endfunction

  // Width able to hold the value n itself, not just 0..n-1.
  function automatic int cntWidth(input int n);
    return (n <= 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ascon_share_shreg.sv
// Shift register for one SHARES-way shared field; shifts W bits per share per beat,
// accepting only the first ENABLE_BEATS beats after a clear or parallel load.
module ascon_share_shreg
  import ascon_io_pkg::*;
#(
  parameter int LEN          = 128,
  parameter int W            = 1,
  parameter int SHARES       = 1,
  parameter int ENABLE_BEATS = LEN / W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  shiftEn,
  input  logic                  loadEn,
  input  logic [SHARES*LEN-1:0] loadVal,
  input  logic [SHARES*W-1:0]   dIn,
  output logic [SHARES*LEN-1:0] q
);

  localparam int BW = cntWidth(ENABLE_BEATS);

  logic [BW-1:0]         beatCnt;
  logic                  active;
  logic [SHARES*LEN-1:0] shifted;

  assign active = (beatCnt < BW'(ENABLE_BEATS));

  for (genvar s = 0; s < SHARES; s++) begin : gShare
    if (LEN > W) begin : gShift
      assign shifted[s*LEN +: LEN] = {q[s*LEN +: LEN-W], dIn[s*W +: W]};
    end else begin : gWhole
      assign shifted[s*LEN +: LEN] = dIn[s*W +: W];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q       <= '0;
      beatCnt <= '0;
    end else if (clear) begin
      q       <= '0;
      beatCnt <= '0;
    end else if (loadEn) begin
      q       <= loadVal;
      beatCnt <= '0;
    end else if (shiftEn && active) begin
      q       <= shifted;
      beatCnt <= beatCnt + 1'b1;
    end
  end

endmodule

// File: rtl/ascon_serial_io.sv
// Flow-controlled, share-preserving serial front-end around the Ascon core:
// deserialise shared inputs, pulse core_start, then stream ciphertext and tag out.
//
// state | meaning
// LOAD  | accepting input beats (in_ready=1)
// START | one-cycle core launch pulse, busy counter cleared
// WAIT  | counting core latency until core_done
// DRAIN | streaming ct/tag beats under out_ready back-pressure
module ascon_serial_io
  import ascon_io_pkg::*;
#(
  parameter int K      = 128,
  parameter int L      = 40,
  parameter int Y      = 40,
  parameter int W      = 1,
  parameter int SHARES = 3,
  parameter int CW     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         abort,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [SHARES*W-1:0]          key_in,
  input  logic [SHARES*W-1:0]          nonce_in,
  input  logic [SHARES*W-1:0]          ad_in,
  input  logic [SHARES*W-1:0]          pt_in,
  output logic [SHARES*K-1:0]          core_key,
  output logic [SHARES*NONCE_BITS-1:0] core_nonce,
  output logic [SHARES*L-1:0]          core_ad,
  output logic [SHARES*Y-1:0]          core_pt,
  output logic                         core_start,
  input  logic                         core_done,
  input  logic [Y-1:0]                 core_ct,
  input  logic [TAG_BITS-1:0]          core_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [W-1:0]                 ct_out,
  output logic [W-1:0]                 tag_out,
  output logic                         out_last,
  output logic [CW-1:0]                busy_cycles
);

  if ((K % W) != 0 || (NONCE_BITS % W) != 0 || (L % W) != 0 || (Y % W) != 0) begin : gBadWidth
    $error("ascon_serial_io: W=%0d must divide K=%0d, 128, L=%0d and Y=%0d", W, K, L, Y);
  end
  if (SHARES < 1 || SHARES > 3) begin : gBadShares
    $error("ascon_serial_io: SHARES=%0d outside 1..3", SHARES);
  end

  localparam int NIN  = beatCount(maxOf(maxOf(K, NONCE_BITS), maxOf(L, Y)), W);
  localparam int NOUT = beatCount(maxOf(Y, TAG_BITS), W);
  localparam int INW  = cntWidth(NIN);
  localparam int OUTW = cntWidth(NOUT);

  ioState_e          state, nextState;
  logic [INW-1:0]    inCnt;
  logic [OUTW-1:0]   outCnt;
  logic              inAccept, outAccept, loadOut, clearRegs;
  logic [CW-1:0]     busyInc1, busyInc2;
  logic [Y-1:0]      ctReg;
  logic [TAG_BITS-1:0] tagReg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= LOAD;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    inAccept  = 1'b0;
    outAccept = 1'b0;
    loadOut   = 1'b0;
    clearRegs = 1'b0;
    case (state)
      LOAD: begin
        if (in_valid) begin
          inAccept = 1'b1;
          if (inCnt == INW'(NIN - 1)) nextState = START;
        end
      end
      START: nextState = WAIT;
      WAIT: begin
        if (core_done) begin
          loadOut   = 1'b1;
          nextState = DRAIN;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          outAccept = 1'b1;
          if (outCnt == OUTW'(NOUT - 1)) begin
            clearRegs = 1'b1;
            nextState = LOAD;
          end
        end
      end
      default: nextState = LOAD;
    endcase
    // abort overrides everything; suppressing the LOAD->START step is what cancels the launch
    if (abort) begin
      nextState = LOAD;
      inAccept  = 1'b0;
      outAccept = 1'b0;
      loadOut   = 1'b0;
      clearRegs = 1'b1;
    end
  end

  assign in_ready   = (state == LOAD);
  assign core_start = (state == START);
  assign out_valid  = (state == DRAIN);
  assign out_last   = (state == DRAIN) && (outCnt == OUTW'(NOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inCnt  <= '0;
      outCnt <= '0;
    end else if (clearRegs) begin
      inCnt  <= '0;
      outCnt <= '0;
    end else begin
      if (inAccept)  inCnt  <= (inCnt == INW'(NIN - 1)) ? '0 : inCnt + 1'b1;
      if (outAccept) outCnt <= outCnt + 1'b1;
    end
  end

  // The done cycle counts twice so the total spans START through done inclusive.
  assign busyInc1 = (&busy_cycles) ? busy_cycles : busy_cycles + 1'b1;
  assign busyInc2 = (&busyInc1) ? busyInc1 : busyInc1 + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_cycles <= '0;
    end else if (!abort) begin
      if (state == START)     busy_cycles <= '0;
      else if (state == WAIT) busy_cycles <= core_done ? busyInc2 : busyInc1;
    end
  end

  ascon_share_shreg #(.LEN(K), .W(W), .SHARES(SHARES), .ENABLE_BEATS(K / W)) uKey (
    .clk(clk), .rst(rst), .clear(clearRegs), .shiftEn(inAccept), .loadEn(1'b0),
    .loadVal('0), .dIn(key_in), .q(core_key)
  );

  ascon_share_shreg #(.LEN(NONCE_BITS), .W(W), .SHARES(SHARES), .ENABLE_BEATS(NONCE_BITS / W)) uNonce (
    .clk(clk), .rst(rst), .clear(clearRegs), .shiftEn(inAccept), .loadEn(1'b0),
    .loadVal('0), .dIn(nonce_in), .q(core_nonce)
  );

  ascon_share_shreg #(.LEN(L), .W(W), .SHARES(SHARES), .ENABLE_BEATS(L / W)) uAd (
    .clk(clk), .rst(rst), .clear(clearRegs), .shiftEn(inAccept), .loadEn(1'b0),
    .loadVal('0), .dIn(ad_in), .q(core_ad)
  );

  ascon_share_shreg #(.LEN(Y), .W(W), .SHARES(SHARES), .ENABLE_BEATS(Y / W)) uPt (
    .clk(clk), .rst(rst), .clear(clearRegs), .shiftEn(inAccept), .loadEn(1'b0),
    .loadVal('0), .dIn(pt_in), .q(core_pt)
  );

  // Output registers shift zeros in, so each stream reads 0 once exhausted.
  ascon_share_shreg #(.LEN(Y), .W(W), .SHARES(1), .ENABLE_BEATS(Y / W)) uCtOut (
    .clk(clk), .rst(rst), .clear(clearRegs), .shiftEn(outAccept), .loadEn(loadOut),
    .loadVal(core_ct), .dIn('0), .q(ctReg)
  );

  ascon_share_shreg #(.LEN(TAG_BITS), .W(W), .SHARES(1), .ENABLE_BEATS(TAG_BITS / W)) uTagOut (
    .clk(clk), .rst(rst), .clear(clearRegs), .shiftEn(outAccept), .loadEn(loadOut),
    .loadVal(core_tag), .dIn('0), .q(tagReg)
  );

  assign ct_out  = ctReg[Y-1 -: W];
  assign tag_out = tagReg[TAG_BITS-1 -: W];

endmodule
